// File: rtl/poly_accumulator.sv
// Modular polynomial accumulator: sums a stream of KYBER_N-coefficient operands mod KYBER_Q,
// LANES coefficients per cycle, and presents the reduced sum once the last term is added.
module poly_accumulator #(
  parameter int unsigned KYBER_N = 256,
  parameter int unsigned LANES   = 16,
  parameter int unsigned KYBER_Q = 3329
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KYBER_N*16-1:0] in_poly,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KYBER_N*16-1:0] out_poly,
  output logic                 busy
);

  localparam int unsigned Beats = KYBER_N / LANES;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [12:0] Q     = 13'(KYBER_Q);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [KYBER_N*12-1:0] op_q, op_d;
  logic                  last_q, last_d;
  logic [KYBER_N*12-1:0] acc_q, acc_d;
  logic [KYBER_N*12-1:0] in_coef;
  logic [KYBER_N*4-1:0]  unused_in_hi;

  // Upper nibble of each input coefficient carries no information and is dropped.
  for (genvar i = 0; i < KYBER_N; i++) begin : g_coef
    assign in_coef[i*12 +: 12]     = in_poly[i*16 +: 12];
    assign unused_in_hi[i*4 +: 4]  = in_poly[i*16+12 +: 4];
    assign out_poly[i*16 +: 16]    = {4'b0000, acc_q[i*12 +: 12]};
  end

  // Raw input may be up to 4095, so one conditional subtract brings it into [0, Q-1].
  function automatic logic [11:0] mod_add(input logic [11:0] acc, input logic [11:0] raw);
    logic [12:0] a;
    logic [12:0] s;
    a = {1'b0, raw};
    if (a >= Q) a = a - Q;
    s = {1'b0, acc} + a;
    if (s >= Q) s = s - Q;
    return s[11:0];
  endfunction

  always_comb begin
    int unsigned idx;
    idx     = 0;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    last_d  = last_q;
    acc_d   = acc_q;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d    = in_coef;
            last_d  = in_last;
            cnt_d   = '0;
            state_d = StAdd;
          end
        end
        StAdd: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            idx = int'(cnt_q) * LANES + l;
            acc_d[idx*12 +: 12] = mod_add(acc_q[idx*12 +: 12], op_q[idx*12 +: 12]);
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(Beats - 1)) begin
            cnt_d   = '0;
            state_d = last_q ? StDone : StIdle;
          end
        end
        StDone: begin
          if (out_ready) begin
            acc_d   = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_poly_accumulator.sv
// Directed bench for poly_accumulator: table of uniform-coefficient sums plus
// hand-written sequences for indexing, backpressure, clear and asynchronous reset.
module tb_poly_accumulator;

  localparam int unsigned N  = 256;
  localparam int unsigned PW = N * 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_poly = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_poly;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  poly_accumulator #(.KYBER_N(256), .LANES(16), .KYBER_Q(3329)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_poly   (in_poly),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_poly  (out_poly),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        two;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [PW-1:0] splat(input logic [15:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < N; i++) p[i*16 +: 16] = v;
    return p;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_poly(input string name, input logic [PW-1:0] got,
                            input logic [PW-1:0] exp);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 0; i < N; i++)
      if (bad < 0 && got[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: coef %0d got %0d expected %0d", name, bad,
               got[bad*16 +: 16], exp[bad*16 +: 16]);
    end
  endtask

  // Offers one operand, then counts cycles until the block is idle or holding a sum.
  task automatic run_term(input logic [PW-1:0] p, input logic last, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    in_poly  = p;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && !in_ready && lat < 100);
  endtask

  task automatic take_output(output logic [PW-1:0] p);
    p = out_poly;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_int("idle_after_take", int'(in_ready), 1);
  endtask

  task automatic sum_and_check(input string name, input logic [PW-1:0] a, input logic [PW-1:0] b,
                               input logic two, input logic [PW-1:0] exp);
    int lat;
    logic [PW-1:0] got;
    if (two) begin
      run_term(a, 1'b0, lat);
      check_int({name, "_lat_mid"}, lat, 16);
      check_int({name, "_no_valid_mid"}, int'(out_valid), 0);
      run_term(b, 1'b1, lat);
    end else begin
      run_term(a, 1'b1, lat);
    end
    check_int({name, "_lat"}, lat, 16);
    check_int({name, "_valid"}, int'(out_valid), 1);
    take_output(got);
    check_poly(name, got, exp);
  endtask

  initial begin
    logic [PW-1:0] pa, pb, pe, snap;
    int lat;

    vecs[0] = '{a: 16'd3328, b: 16'd0,    two: 1'b0, exp: 16'd3328};
    vecs[1] = '{a: 16'd3328, b: 16'd2,    two: 1'b1, exp: 16'd1};
    vecs[2] = '{a: 16'd1665, b: 16'd1665, two: 1'b1, exp: 16'd1};
    vecs[3] = '{a: 16'hFD01, b: 16'd0,    two: 1'b0, exp: 16'd0};
    vecs[4] = '{a: 16'h0FFF, b: 16'd0,    two: 1'b0, exp: 16'd766};
    vecs[5] = '{a: 16'd1000, b: 16'd2000, two: 1'b1, exp: 16'd3000};
    vecs[6] = '{a: 16'd3000, b: 16'd1000, two: 1'b1, exp: 16'd671};
    vecs[7] = '{a: 16'h0FFF, b: 16'h0FFF, two: 1'b1, exp: 16'd1532};
    vecs[8] = '{a: 16'hA005, b: 16'h5006, two: 1'b1, exp: 16'd11};
    vecs[9] = '{a: 16'd0,    b: 16'd0,    two: 1'b0, exp: 16'd0};

    #3;
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_poly("reset_out_poly", out_poly, '0);
    #19;
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      sum_and_check($sformatf("vec%0d", v), splat(vecs[v].a), splat(vecs[v].b), vecs[v].two,
                    splat(vecs[v].exp));
    end

    // Distinct value per coefficient exposes lane/beat indexing errors.
    for (int i = 0; i < N; i++) begin
      pa[i*16 +: 16] = 16'(i * 13);
      pb[i*16 +: 16] = 16'hF000 | 16'(i * 7 + 100);
      pe[i*16 +: 16] = 16'((i * 13 + i * 7 + 100) % 3329);
    end
    sum_and_check("index_single", pa, '0, 1'b0, pa);
    sum_and_check("index_pair", pa, pb, 1'b1, pe);

    // Backpressure: sum must hold while out_ready stays low.
    run_term(splat(16'd5), 1'b1, lat);
    check_int("bp_lat", lat, 16);
    snap = out_poly;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_int("bp_valid_hold", int'(out_valid), 1);
      check_int("bp_in_ready_low", int'(in_ready), 0);
      check_poly("bp_poly_hold", out_poly, snap);
    end
    take_output(pa);
    check_poly("bp_value", pa, splat(16'd5));
    sum_and_check("bp_restart", splat(16'd9), '0, 1'b0, splat(16'd9));

    // Clear in ADD cycle 5 with a new operand offered.
    @(negedge clk);
    in_poly = splat(16'd100);
    in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_poly = splat(16'd50);
    repeat (4) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check_int("clear_add_busy", int'(busy), 0);
    check_int("clear_add_out_valid", int'(out_valid), 0);
    check_int("clear_add_in_ready", int'(in_ready), 1);
    check_poly("clear_add_acc", out_poly, '0);

    // Clear coincident with an idle handshake drops the operand.
    @(negedge clk);
    in_poly = splat(16'd50);
    in_last = 1'b1;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
    check_int("clear_hs_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check_int("clear_hs_busy_later", int'(busy), 0);
    sum_and_check("clear_restart", splat(16'd3), '0, 1'b0, splat(16'd3));

    // Asynchronous reset mid-ADD, off the clock edge.
    @(negedge clk);
    in_poly = splat(16'd200);
    in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("arst_out_valid", int'(out_valid), 0);
    check_int("arst_busy", int'(busy), 0);
    check_poly("arst_out_poly", out_poly, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sum_and_check("arst_restart", splat(16'd7), '0, 1'b0, splat(16'd7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_accumulator.md
POLY_ACCUMULATOR -- requirements
Module: poly_accumulator

Interface
REQ-001 Parameter KYBER_N, default 256: coefficients per polynomial.
REQ-002 Parameter LANES, default 16: coefficients processed per cycle; KYBER_N divisible by LANES.
REQ-003 Parameter KYBER_Q, default 3329: modulus.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port clear  input  1: synchronous abort/zero command.
REQ-007 Port in_valid  input  1: operand offered.
REQ-008 Port in_ready  output  1: block accepts operand this cycle.
REQ-009 Port in_poly  input  KYBER_N*16: operand, coefficient i in bits [i*16+:16], from the small/normal polynomial multiplexer.
REQ-010 Port in_last  input  1: operand is the final term of the sum; sampled with in_poly.
REQ-011 Port out_valid  output  1: sum available.
REQ-012 Port out_ready  input  1: consumer takes sum.
REQ-013 Port out_poly  output  KYBER_N*16: sum, same packing; bits [i*16+12+:4] always 0.
REQ-014 Port busy  output  1: high in ADD or DONE.

Function
REQ-015 States IDLE, ADD, DONE; one-hot or binary encoding at implementer's choice.
REQ-016 IDLE: in_ready=1, out_valid=0; handshake = in_valid & in_ready.
REQ-017 On handshake: in_poly and in_last latched into an operand register, lane counter set to 0, state -> ADD.
REQ-018 ADD: in_ready=0; each cycle coefficients [cnt*LANES, cnt*LANES+LANES-1] updated, cnt increments; ADD lasts exactly KYBER_N/LANES cycles (16 by default).
REQ-019 Per-coefficient rule: a = in[11:0]; if a >= KYBER_Q then a = a - KYBER_Q; s = acc + a; if s >= KYBER_Q then s = s - KYBER_Q; acc = s. Bits [15:12] of input ignored; acc is 12 bits, always in [0, KYBER_Q-1].
REQ-020 After final ADD cycle: latched in_last=1 -> DONE; else -> IDLE.
REQ-021 Latency: handshake in cycle T; in_ready high again in T+17, or out_valid high in T+17 (LANES=16).
REQ-022 DONE: out_valid=1, in_ready=0, out_poly=acc, held stable until out_ready.
REQ-023 In DONE with out_ready=1: acc zeroed, state -> IDLE next cycle; out_ready ignored in other states.
REQ-024 out_poly reflects acc continuously; it is meaningful only while out_valid=1.
REQ-025 clear=1 in any state: next cycle acc=0, cnt=0, state=IDLE, out_valid=0; clear overrides a simultaneous input handshake (operand dropped) and a simultaneous output handshake.
REQ-026 A single operand with in_last=1 from zero acc yields its reduced value, i.e. the block also serves as a reducer.
REQ-027 in_valid while in_ready=0 has no effect; upstream holds data until accepted.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, acc=0, operand register=0, cnt=0; outputs in_ready=1 (once rst_n high), out_valid=0, busy=0, out_poly=0.
REQ-030 Reset asserted mid-ADD or in DONE discards partial sum; no output handshake occurs.

Verification
REQ-031 Single term: in_poly all coefficients 3328, in_last=1 -> out_valid at T+17, all out coefficients 3328.
REQ-032 Wrap: operands all-3328 (in_last=0) then all-2 (in_last=1) -> all coefficients 1; operands 1665+1665 -> 1.
REQ-033 Input reduction: coefficient field 16'hF D01 (low 12 bits 3329) and 16'h0FFF (4095) with in_last=1 -> outputs 0 and 766.
REQ-034 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and out_poly stable, in_ready=0; then out_ready=1 -> IDLE, next sum starts from 0.
REQ-035 clear at ADD cycle 5 with in_valid=1 -> IDLE next cycle, acc all 0, no out_valid; clear coincident with IDLE handshake -> operand not accepted, busy stays 0.
REQ-036 rst_n pulsed low mid-ADD (asynchronous to clk) -> out_valid, busy 0 immediately; after release, single term all-7 with in_last=1 -> output all 7.
